imm_encoder: RTL and testbench

- Inverse of the core's immediate extender: packs a 32-bit signed immediate into the I/S/B/J bit positions of an instruction word.
- Also checks that the immediate is representable in the chosen format.
- 2-stage valid/ready pipeline with throughput of 1 word per cycle.
- Sits in the debug/program-loader path that builds instruction words to write into instruction memory.

---
 rtl/imm_encoder.sv | 113 +++++++++++
 tb/tb_imm_encoder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// Immediate encoder: packs a signed 32-bit immediate into the I/S/B/J fields of
// an instruction word, flags unrepresentable values, 2-stage valid/ready pipe.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       immsrc,
  input  logic [31:0]      imm,
  input  logic [31:0]      base_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             range_err,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] FMT_I = 2'b00;
  localparam logic [1:0] FMT_S = 2'b01;
  localparam logic [1:0] FMT_B = 2'b10;

  logic        s1_valid;
  logic [1:0]  s1_immsrc;
  logic [31:0] s1_imm;
  logic [31:0] s1_base;
  logic        s2_valid;
  logic        s2_load;
  logic [31:0] enc_instr;
  logic        enc_err;

  assign out_valid = s2_valid;
  assign s2_load   = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_load;

  // Field overwrites on a copy of base_instr are the clear-then-OR packing.
  always_comb begin
    enc_instr = s1_base;
    enc_err   = 1'b0;
    case (s1_immsrc)
      FMT_I: begin
        enc_instr[31:20] = s1_imm[11:0];
        enc_err          = s1_imm[31:12] != {20{s1_imm[11]}};
      end
      FMT_S: begin
        enc_instr[31:25] = s1_imm[11:5];
        enc_instr[11:7]  = s1_imm[4:0];
        enc_err          = s1_imm[31:12] != {20{s1_imm[11]}};
      end
      FMT_B: begin
        enc_instr[31]    = s1_imm[12];
        enc_instr[30:25] = s1_imm[10:5];
        enc_instr[11:8]  = s1_imm[4:1];
        enc_instr[7]     = s1_imm[11];
        enc_err          = (s1_imm[31:13] != {19{s1_imm[12]}}) || s1_imm[0];
      end
      default: begin
        enc_instr[31]    = s1_imm[20];
        enc_instr[30:21] = s1_imm[10:1];
        enc_instr[20]    = s1_imm[11];
        enc_instr[19:12] = s1_imm[19:12];
        enc_err          = (s1_imm[31:21] != {11{s1_imm[20]}}) || s1_imm[0];
      end
    endcase
  end

  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values and the handshake terms stay race-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  // NOTE: stage-1 payload carries no reset; it is only observed through
  // s1_valid, so resetting it would add reset fan-out for no behaviour.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      s1_immsrc <= immsrc;
      s1_imm    <= imm;
      s1_base   <= base_instr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      instr     <= '0;
      range_err <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        instr     <= enc_instr;
        range_err <= enc_err;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enc_cnt <= '0;
      err_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (enc_cnt != '1) enc_cnt <= enc_cnt + CNT_W'(1);
      if (range_err && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vector table, backpressure,
// random round-trip through a reference immediate extender, reset and saturation.
module tb_imm_encoder;

  typedef struct {
    logic [1:0]  immsrc;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] exp_instr;
    logic        exp_err;
    logic        chk;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [1:0]  immsrc;
  logic [31:0] imm;
  logic [31:0] base_instr;

  logic        in_ready, out_valid, range_err;
  logic [31:0] instr;
  logic [15:0] enc_cnt, err_cnt;

  logic        in_ready_s, out_valid_s, range_err_s;
  logic [31:0] instr_s;
  logic [3:0]  enc_cnt_s, err_cnt_s;

  always #5 clk = ~clk;

  imm_encoder #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .immsrc(immsrc), .imm(imm), .base_instr(base_instr),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
    .range_err(range_err), .enc_cnt(enc_cnt), .err_cnt(err_cnt)
  );

  imm_encoder #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .immsrc(immsrc), .imm(imm), .base_instr(base_instr),
    .out_valid(out_valid_s), .out_ready(out_ready), .instr(instr_s),
    .range_err(range_err_s), .enc_cnt(enc_cnt_s), .err_cnt(err_cnt_s)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int out_xfers = 0;
  int accepted = 0;
  int gen_cnt  = 0;
  int gen_target = 0;
  bit rand_mode = 0;
  bit lat_chk  = 0;
  bit held_valid = 0;
  logic [31:0] held_instr;
  logic        held_err;

  vec_t pending[$];
  vec_t sb[$];
  int   acc_cyc[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference immediate extender of the core.
  function automatic logic [31:0] extend(input logic [1:0] src, input logic [31:0] i);
    case (src)
      2'b00:   return {{20{i[31]}}, i[31:20]};
      2'b01:   return {{20{i[31]}}, i[31:25], i[11:7]};
      2'b10:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    logic [31:0] r;
    r = $urandom;
    v.immsrc = 2'($urandom_range(0, 3));
    case (v.immsrc)
      2'b00, 2'b01: v.imm = {{20{r[11]}}, r[11:0]};
      2'b10:        v.imm = {{19{r[12]}}, r[12:1], 1'b0};
      default:      v.imm = {{11{r[20]}}, r[20:1], 1'b0};
    endcase
    v.base = $urandom;
    v.exp_instr = '0;
    v.exp_err = 1'b0;
    v.chk = 1'b0;
    return v;
  endfunction

  function automatic vec_t mk(input logic [1:0] s, input logic [31:0] i, input logic [31:0] b,
                              input logic [31:0] e, input logic ee);
    vec_t v;
    v.immsrc = s; v.imm = i; v.base = b; v.exp_instr = e; v.exp_err = ee; v.chk = 1'b1;
    return v;
  endfunction

  // One clock: drive at the falling edge, sample 1ns later, let the rising edge act.
  task automatic run_cycles(input int n);
    vec_t v;
    bit acc, xfer;
    int a;
    for (int k = 0; k < n; k++) begin
      if (rand_mode) begin
        out_ready = 1'($urandom_range(0, 1));
        if (pending.size() == 0 && gen_cnt < gen_target) begin
          pending.push_back(rand_vec());
          gen_cnt++;
        end
      end
      if (pending.size() != 0) begin
        in_valid = 1'b1;
        immsrc = pending[0].immsrc;
        imm = pending[0].imm;
        base_instr = pending[0].base;
      end else begin
        in_valid = 1'b0;
        immsrc = 2'($urandom);
        imm = $urandom;
        base_instr = $urandom;
      end
      #1;
      if (held_valid) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_instr", instr, held_instr);
        check("hold_err", 32'(range_err), 32'(held_err));
      end
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (xfer) begin
        out_xfers++;
        if (sb.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          v = sb.pop_front();
          a = acc_cyc.pop_front();
          if (lat_chk) check("latency", 32'(cyc - a), 32'd2);
          if (v.chk) begin
            check("instr", instr, v.exp_instr);
            check("range_err", 32'(range_err), 32'(v.exp_err));
          end else begin
            check("roundtrip", extend(v.immsrc, instr), v.imm);
            check("rt_range_err", 32'(range_err), 32'd0);
          end
        end
      end
      held_valid = out_valid && !out_ready;
      held_instr = instr;
      held_err   = range_err;
      if (acc) begin
        accepted++;
        sb.push_back(pending.pop_front());
        acc_cyc.push_back(cyc);
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    vecs[0] = mk(2'b00, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
    vecs[1] = mk(2'b01, 32'h0000_07FF, 32'h0000_2023, 32'h7E00_2FA3, 1'b0);
    vecs[2] = mk(2'b10, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0);
    vecs[3] = mk(2'b11, 32'h0000_0800, 32'h0000_006F, 32'h0010_006F, 1'b0);
    vecs[4] = mk(2'b00, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1);
    vecs[5] = mk(2'b10, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1);
    vecs[6] = mk(2'b11, 32'h0010_0000, 32'h0000_006F, 32'h8000_006F, 1'b1);
    vecs[7] = mk(2'b00, 32'h0000_0000, 32'hFFFF_FFFF, 32'h000F_FFFF, 1'b0);

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    immsrc = '0; imm = '0; base_instr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_instr", instr, 32'd0);
    check("rst_range_err", 32'(range_err), 32'd0);
    check("rst_enc_cnt", 32'(enc_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);

    // Format encodings, back to back, fixed 2-cycle latency.
    lat_chk = 1;
    for (int i = 0; i < 4; i++) pending.push_back(vecs[i]);
    run_cycles(8);
    check("t1_enc_cnt", 32'(enc_cnt), 32'd4);
    check("t1_err_cnt", 32'(err_cnt), 32'd0);

    // Range errors and fully-set base word.
    for (int i = 4; i < 8; i++) pending.push_back(vecs[i]);
    run_cycles(8);
    lat_chk = 0;
    check("t2_enc_cnt", 32'(enc_cnt), 32'd8);
    check("t2_err_cnt", 32'(err_cnt), 32'd3);

    // Backpressure: only two words fit, then drain one per cycle.
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++)
      pending.push_back(mk(2'b00, 32'(k), 32'h0000_0013, (32'(k) << 20) | 32'h13, 1'b0));
    run_cycles(6);
    #1;
    check("bp_pending", 32'(pending.size()), 32'd4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_enc_cnt", 32'(enc_cnt), 32'd8);
    out_ready = 1'b1;
    begin
      int x0;
      x0 = out_xfers;
      run_cycles(6);
      check("bp_rate", 32'(out_xfers - x0), 32'd6);
    end
    check("bp_sb_empty", 32'(sb.size() + pending.size()), 32'd0);
    check("bp_enc_cnt2", 32'(enc_cnt), 32'd14);

    // Random in-range round trip with random backpressure.
    rand_mode = 1; gen_cnt = 0; gen_target = 10000;
    begin
      int budget;
      budget = 0;
      while ((gen_cnt < gen_target || pending.size() != 0 || sb.size() != 0) && budget < 60000) begin
        run_cycles(1);
        budget++;
      end
      check("rand_done", 32'(sb.size() + pending.size() + gen_target - gen_cnt), 32'd0);
    end
    rand_mode = 0; out_ready = 1'b1;
    run_cycles(2);
    check("rand_enc_cnt", 32'(enc_cnt), 32'd10014);
    check("rand_err_cnt", 32'(err_cnt), 32'd3);
    check("rand_sat_enc", 32'(enc_cnt_s), 32'd15);

    // Reset with both stages full: asynchronous clear, nothing stale afterwards.
    out_ready = 1'b0;
    pending.push_back(vecs[0]);
    pending.push_back(vecs[1]);
    run_cycles(2);
    #1;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    check("pre_rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_enc_cnt", 32'(enc_cnt), 32'd0);
    check("arst_err_cnt", 32'(err_cnt), 32'd0);
    check("arst_sat_enc", 32'(enc_cnt_s), 32'd0);
    sb.delete(); acc_cyc.delete(); pending.delete(); held_valid = 0;
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    begin
      int x0;
      x0 = out_xfers;
      run_cycles(4);
      check("post_rst_no_out", 32'(out_xfers - x0), 32'd0);
    end

    // Saturation of the 4-bit counters.
    for (int k = 0; k < 20; k++) pending.push_back(vecs[4]);
    run_cycles(25);
    check("sat_enc", 32'(enc_cnt_s), 32'd15);
    check("sat_err", 32'(err_cnt_s), 32'd15);
    check("wide_enc", 32'(enc_cnt), 32'd20);
    check("wide_err", 32'(err_cnt), 32'd20);
    pending.push_back(vecs[4]);
    pending.push_back(vecs[5]);
    run_cycles(5);
    check("sat_enc_hold", 32'(enc_cnt_s), 32'd15);
    check("sat_err_hold", 32'(err_cnt_s), 32'd15);
    check("wide_enc2", 32'(enc_cnt), 32'd22);
    check("wide_err2", 32'(err_cnt), 32'd22);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
